// File: rtl/harness_pkg.sv
// harness_pkg: shared dump FSM states and UART framing constants for the filter test harness
package harness_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_e;
  localparam int FRAME_BITS       = 10;
  localparam int BYTES_PER_WORD   = 4;
  localparam int CLKS_PER_BIT_DEF = 434;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one byte per load, each bit held CLKS_PER_BIT cycles
// ports: load_i/byte_i start a frame (a load always restarts, so back-to-back loads on
//        frame_done_o give gapless frames); tx_o idles high; frame_done_o is high on the
//        final cycle of the stop bit
module uart_tx_byte
  import harness_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       frame_done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt_q;
  logic [3:0] bit_q;
  logic [8:0] sh_q;
  logic act_q, tx_q, bit_end;
  assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign frame_done_o = act_q && bit_end && bit_q == 4'(FRAME_BITS - 1);
  assign tx_o = tx_q;
  // sh_q carries the data bits plus the stop bit, so the stop bit simply shifts out last
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      tx_q  <= 1'b1;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= '1;
    end else if (load_i) begin
      act_q <= 1'b1;
      tx_q  <= 1'b0;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q  <= {1'b1, byte_i};
    end else if (act_q) begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      if (frame_done_o) begin
        act_q <= 1'b0;
        tx_q  <= 1'b1;
      end else if (bit_end) begin
        bit_q <= bit_q + 4'd1;
        tx_q  <= sh_q[0];
        sh_q  <= {1'b1, sh_q[8:1]};
      end
    end
  end
endmodule

// File: rtl/result_uart_dump.sv
// result_uart_dump: walks result RAM 0..DEPTH-1 and streams each word MSB byte first over 8N1 UART
// ports: start requests a dump (ignored while busy); ram_addr/ram_rden/ram_q read the RAM
//        with RD_LAT cycles latency; tx is the serial pin (idle high); busy spans the dump;
//        done pulses for one cycle after the last stop bit
module result_uart_dump
  import harness_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 256,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int RD_LAT       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  dump_state_e state_q;
  logic [1:0] lat_q, byte_q;
  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic rden_q, busy_q, done_q;
  logic fetch_last, last_byte, frame_done, load;
  logic [7:0] load_byte;
  assign fetch_last = state_q == FETCH && lat_q == 2'(RD_LAT);
  assign last_byte  = byte_q == 2'(BYTES_PER_WORD - 1);
  // the first byte bypasses word_q so its start bit lands on the first SEND cycle
  assign load      = fetch_last || (state_q == SEND && frame_done && !last_byte);
  assign load_byte = fetch_last ? ram_q[DATA_W-1 -: 8] : word_q[DATA_W-9 -: 8];
  assign ram_addr  = addr_q;
  assign ram_rden  = rden_q;
  assign busy      = busy_q;
  assign done      = done_q;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .byte_i      (load_byte),
    .tx_o        (tx),
    .frame_done_o(frame_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) word_q <= fetch_last ? ram_q : word_q << 8;
      case (state_q)
        IDLE: if (start) begin
          state_q <= FETCH;
          lat_q   <= '0;
          addr_q  <= '0;
          rden_q  <= 1'b1;
          busy_q  <= 1'b1;
        end
        FETCH: begin
          lat_q <= lat_q + 2'd1;
          if (fetch_last) begin
            state_q <= SEND;
            byte_q  <= '0;
            rden_q  <= 1'b0;
          end
        end
        SEND: if (frame_done) begin
          if (!last_byte) byte_q <= byte_q + 2'd1;
          else if (addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= FETCH;
            lat_q   <= '0;
            addr_q  <= addr_q + 1'b1;
            rden_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          addr_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_uart_dump.sv
// tb_result_uart_dump: scoreboard bench, three DUTs with RD_LAT 1/2/3 sharing clk and rst
module tb_result_uart_dump;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int AW    = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start [3];
  logic [AW-1:0] ram_addr [3];
  logic ram_rden [3];
  logic tx [3];
  logic busy [3];
  logic done [3];
  logic [31:0] ram_q [3];
  logic [31:0] mem [3][DEPTH];
  logic [7:0] exp_b [3][$];
  int exp_done [3][$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g + 1;
    logic [AW-1:0] a_p [3];
    logic v_p [3];
    result_uart_dump #(
      .ADDR_W(AW), .DATA_W(32), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .RD_LAT(L)
    ) dut (
      .clk(clk), .rst(rst), .start(start[g]), .ram_addr(ram_addr[g]), .ram_rden(ram_rden[g]),
      .ram_q(ram_q[g]), .tx(tx[g]), .busy(busy[g]), .done(done[g])
    );
    always @(posedge clk) begin
      a_p[0] <= ram_addr[g];
      a_p[1] <= a_p[0];
      a_p[2] <= a_p[1];
      v_p[0] <= ram_rden[g];
      v_p[1] <= v_p[0];
      v_p[2] <= v_p[1];
    end
    // read data is only good exactly L cycles after an enabled address; garbage otherwise
    assign ram_q[g] = v_p[L-1] ? mem[g][a_p[L-1][1:0]] : 32'hDEAD_BEEF;
    initial begin
      int cnt;
      bit act, pb, pd;
      logic [9:0] fr, ef;
      act = 0; pb = 0; pd = 0; cnt = 0; fr = '0;
      forever begin
        @(negedge clk);
        #1;
        if (rst) act = 0;
        else begin
          if (act) cnt++;
          else if (!tx[g]) begin act = 1; cnt = 0; end
          if (act && cnt % CPB == CPB / 2) begin
            fr[cnt / CPB] = tx[g];
            if (cnt / CPB == 9) begin
              act = 0;
              if (exp_b[g].size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL frame%0d: got unexpected frame %h, expected none", g, fr);
              end else begin
                ef = {1'b1, exp_b[g].pop_front(), 1'b0};
                check($sformatf("frame%0d", g), fr, ef);
              end
            end
          end
        end
        if (done[g]) begin
          if (exp_done[g].size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL done%0d: got unexpected done at cycle %0d, expected none", g, cyc);
          end else check($sformatf("done_cycle%0d", g), cyc, exp_done[g].pop_front());
          check($sformatf("busy_at_done%0d", g), busy[g], 0);
          check($sformatf("busy_before_done%0d", g), pb, 1);
        end
        if (pd) check($sformatf("addr_after_done%0d", g), ram_addr[g], 0);
        pb = busy[g];
        pd = done[g];
      end
    end
  end
  task automatic start_dump(int g, int nb, output int t);
    start[g] = 1'b1;
    t = cyc;
    for (int i = 0; i < nb; i++) exp_b[g].push_back(8'(mem[g][i / 4] >> (24 - 8 * (i % 4))));
    if (nb == 4 * DEPTH) exp_done[g].push_back(t + 1 + DEPTH * (g + 2 + 40 * CPB));
    @(negedge clk);
    start[g] = 1'b0;
  endtask
  task automatic wait_idle(int g);
    int n = 0;
    while ((exp_b[g].size() != 0 || exp_done[g].size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain%0d_in_time", g), n < 3000, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic rand_mem(int g);
    for (int i = 0; i < DEPTH; i++) mem[g][i] = $urandom;
  endtask
  initial begin
    int t, t2, low, g;
    logic [9:0] fr;
    logic [39:0] w, ew;
    logic b3, b4;
    for (int i = 0; i < 3; i++) begin start[i] = 1'b0; rand_mem(i); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_state%0d", i), {tx[i], busy[i], done[i], ram_rden[i], ram_addr[i]}, {4'b1000, 8'h00});
    low = 0;
    repeat (1000) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (!tx[i] || busy[i]) low++;
    end
    check("idle_quiet", low, 0);
    mem[1][0] = 32'hA5C30F81;
    start_dump(1, 16, t);
    check("fetch_entry", {busy[1], ram_rden[1], ram_addr[1]}, {2'b11, 8'h00});
    repeat (2) @(negedge clk);
    check("tx_before_first_bit", tx[1], 1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      w[i] = tx[1];
      ew[i] = fr[i / 4];
    end
    check("first_frame_wave", w, ew);
    wait_idle(1);
    mem[1][0] = 32'h00000000;
    mem[1][1] = 32'hFFFFFFFF;
    mem[1][2] = 32'h12345678;
    mem[1][3] = 32'h80000001;
    start_dump(1, 16, t);
    for (int k = 2; k <= 653; k++) begin
      @(negedge clk);
      start[1] = (k == 50 || k == 653);
    end
    rand_mem(1);
    @(negedge clk);
    start_dump(1, 16, t2);
    check("restart_after_done_cycle", t2 - t, 654);
    wait_idle(1);
    rand_mem(1);
    start_dump(1, 6, t);
    repeat (259) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {tx[1], busy[1], done[1], ram_rden[1], ram_addr[1]}, {4'b1000, 8'h00});
    check("abort_drained", exp_b[1].size(), 0);
    repeat (5) @(negedge clk);
    rand_mem(1);
    start_dump(1, 16, t);
    @(negedge clk);
    @(negedge clk);
    b3 = tx[1];
    @(negedge clk);
    b4 = tx[1];
    check("restart_first_bit", {b3, b4}, 2'b10);
    wait_idle(1);
    for (int i = 0; i < 3; i += 2) begin
      mem[i][0] = 32'h00000000;
      mem[i][1] = 32'hFFFFFFFF;
      mem[i][2] = 32'h12345678;
      mem[i][3] = 32'h80000001;
    end
    start[0] = 1'b1;
    start_dump(0, 16, t);
    start_dump(2, 16, t2);
    wait_idle(0);
    wait_idle(2);
    for (int r = 0; r < 4; r++) begin
      g = $urandom_range(0, 2);
      rand_mem(g);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      start_dump(g, 16, t);
      wait_idle(g);
    end
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("queues_empty%0d", i), exp_b[i].size() + exp_done[i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
